// File: rtl/gol_ctrl_pkg.sv
// Shared types and constants for the Game-of-Life generation scheduler.
package gol_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOST,
    LOAD,
    RUN,
    STORE
  } state_t;

  localparam int               POS_W         = 2;
  localparam logic [POS_W-1:0] POS_LAST      = 2'd3;
  localparam int               DEFAULT_DELAY = 100_000_000;

endpackage

// File: rtl/gen_period_timer.sv
// Saturating free-run period counter: counts enabled cycles up to DELAY-1 and flags expiry.
module gen_period_timer
  import gol_ctrl_pkg::*;
#(
  parameter int DELAY = DEFAULT_DELAY
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int               CNT_W = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DELAY - 1);

  logic [CNT_W-1:0] count;

  // With DELAY=1 the count never leaves zero, so every enabled cycle is already expired.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/gen_scheduler.sv
// Generation sequencer for the Game-of-Life array: load, compute, write-back and host arbitration.
// Optional macro GEN_LIMIT_EN adds a gen_limit input that caps free-running generations.
module gen_scheduler
  import gol_ctrl_pkg::*;
#(
  parameter int DELAY = DEFAULT_DELAY,
  parameter int GEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_en,
  input  logic             step,
  input  logic             load_req,
  input  logic             mem_ack,
  input  logic             host_req,
`ifdef GEN_LIMIT_EN
  input  logic [GEN_W-1:0] gen_limit,
`endif
  output logic             host_gnt,
  output logic             write_array,
  output logic             run,
  output logic [POS_W-1:0] pos,
  output logic             write_mem,
  output logic             busy,
  output logic [GEN_W-1:0] gen_count,
  output logic             gen_done
);

  state_t           state;
  state_t           state_next;
  logic [POS_W-1:0] pos_next;
  logic [GEN_W-1:0] gen_count_next;
  logic             done_pulse;
  logic             timer_expired;
  logic             timer_clear;
  logic             timer_en;
  logic             limit_hit;
  logic             free_start;
  logic             idle_exit;

`ifdef GEN_LIMIT_EN
  assign limit_hit = (gen_limit != '0) && (gen_count >= gen_limit);
`else
  assign limit_hit = 1'b0;
`endif

  assign free_start = run_en && timer_expired && !limit_hit;

  // The period restarts whenever free-run is disabled or the scheduler leaves IDLE.
  assign idle_exit   = (state == IDLE) && (state_next != IDLE);
  assign timer_en    = (state == IDLE) && run_en;
  assign timer_clear = !run_en || idle_exit;

  gen_period_timer #(
    .DELAY(DELAY)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(timer_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pos       <= '0;
      gen_count <= '0;
    end else begin
      state     <= state_next;
      pos       <= pos_next;
      gen_count <= gen_count_next;
    end
  end

  always_comb begin
    state_next     = state;
    pos_next       = pos;
    gen_count_next = gen_count;
    done_pulse     = 1'b0;
    unique case (state)
      IDLE: begin
        if (host_req) begin
          state_next = HOST;
        end else if (load_req) begin
          state_next = LOAD;
          pos_next   = '0;
        end else if (step || free_start) begin
          state_next = RUN;
          pos_next   = '0;
        end
      end
      HOST: begin
        if (!host_req) begin
          state_next = IDLE;
        end
      end
      LOAD: begin
        if (mem_ack) begin
          if (pos == POS_LAST) begin
            state_next     = IDLE;
            pos_next       = '0;
            gen_count_next = '0;
          end else begin
            pos_next = pos + POS_W'(1);
          end
        end
      end
      RUN: begin
        // Compute takes one cycle per quadrant with no handshake.
        if (pos == POS_LAST) begin
          state_next = STORE;
          pos_next   = '0;
        end else begin
          pos_next = pos + POS_W'(1);
        end
      end
      STORE: begin
        if (mem_ack) begin
          if (pos == POS_LAST) begin
            state_next     = IDLE;
            pos_next       = '0;
            gen_count_next = gen_count + GEN_W'(1);
            done_pulse     = 1'b1;
          end else begin
            pos_next = pos + POS_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        pos_next   = '0;
      end
    endcase
  end

  assign host_gnt    = (state == HOST);
  assign write_array = (state == LOAD);
  assign run         = (state == RUN);
  assign write_mem   = (state == STORE);
  assign busy        = (state != IDLE);
  // A reset in the completing cycle aborts the generation, so no pulse is reported.
  assign gen_done    = done_pulse && !reset;

endmodule

// File: tb/tb_gen_scheduler.sv
// Self-checking bench for gen_scheduler: vector table, directed corner sequences and a randomized model comparison.
module tb_gen_scheduler;

  localparam int DELAY = 8;
  localparam int GEN_W = 16;

  localparam int M_IDLE  = 0;
  localparam int M_HOST  = 1;
  localparam int M_LOAD  = 2;
  localparam int M_RUN   = 3;
  localparam int M_STORE = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             run_en;
  logic             step;
  logic             load_req;
  logic             mem_ack;
  logic             host_req;
`ifdef GEN_LIMIT_EN
  logic [GEN_W-1:0] gen_limit;
`endif
  logic             host_gnt;
  logic             write_array;
  logic             run;
  logic [1:0]       pos;
  logic             write_mem;
  logic             busy;
  logic [GEN_W-1:0] gen_count;
  logic             gen_done;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: current activity, active quadrant, generation tally, idle cycles with run_en.
  int m_mode;
  int m_quad;
  int m_gen;
  int m_wait;

  typedef struct {
    logic        run_en;
    logic        step;
    logic        load_req;
    logic        mem_ack;
    logic        host_req;
    logic [23:0] exp_out;
  } vec_t;

  vec_t vecs[$];

  gen_scheduler #(
    .DELAY(DELAY),
    .GEN_W(GEN_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run_en     (run_en),
    .step       (step),
    .load_req   (load_req),
    .mem_ack    (mem_ack),
    .host_req   (host_req),
`ifdef GEN_LIMIT_EN
    .gen_limit  (gen_limit),
`endif
    .host_gnt   (host_gnt),
    .write_array(write_array),
    .run        (run),
    .pos        (pos),
    .write_mem  (write_mem),
    .busy       (busy),
    .gen_count  (gen_count),
    .gen_done   (gen_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic ren, input logic stp, input logic ld,
                               input logic ack, input logic hr);
    run_en   = ren;
    step     = stp;
    load_req = ld;
    mem_ack  = ack;
    host_req = hr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [23:0] pack_out(input logic hg, input logic wa, input logic r,
                                           input logic [1:0] p, input logic wm, input logic b,
                                           input logic gd, input logic [15:0] gc);
    return {hg, wa, r, p, wm, b, gd, gc};
  endfunction

  function automatic logic [23:0] dut_out();
    return pack_out(host_gnt, write_array, run, pos, write_mem, busy, gen_done, gen_count);
  endfunction

  function automatic logic [23:0] e_idle(input int gc);
    return pack_out(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'(gc));
  endfunction

  function automatic logic [23:0] e_run(input int p, input int gc);
    return pack_out(1'b0, 1'b0, 1'b1, 2'(p), 1'b0, 1'b1, 1'b0, 16'(gc));
  endfunction

  function automatic logic [23:0] e_wm(input int p, input logic gd, input int gc);
    return pack_out(1'b0, 1'b0, 1'b0, 2'(p), 1'b1, 1'b1, gd, 16'(gc));
  endfunction

  function automatic vec_t mkv(input logic ren, input logic stp, input logic ld,
                               input logic ack, input logic hr, input logic [23:0] e);
    vec_t v;
    v.run_en   = ren;
    v.step     = stp;
    v.load_req = ld;
    v.mem_ack  = ack;
    v.host_req = hr;
    v.exp_out  = e;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic finish_gen(input string name);
    bit seen;
    bit ok;
    seen = 0;
    ok   = 0;
    for (int c = 0; c < 100; c++) begin
      sample();
      if (busy) begin
        seen = 1;
      end else if (seen) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
    tick();
  endtask

  task automatic count_idle_until_run(output int n, output bit ok);
    n  = 0;
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      sample();
      if (run && n > 0) begin
        ok = 1;
        tick();
        break;
      end
      if (!busy) n++;
      tick();
    end
  endtask

  function automatic logic [23:0] model_out();
    return pack_out(m_mode == M_HOST, m_mode == M_LOAD, m_mode == M_RUN, 2'(m_quad),
                    m_mode == M_STORE, m_mode != M_IDLE,
                    (m_mode == M_STORE) && (m_quad == 3) && mem_ack && !reset, 16'(m_gen));
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_update();
    bit free_ok;
    if (reset) begin
      m_mode = M_IDLE;
      m_quad = 0;
      m_gen  = 0;
      m_wait = 0;
      return;
    end
    case (m_mode)
      M_IDLE: begin
        free_ok = run_en && (m_wait >= DELAY - 1);
`ifdef GEN_LIMIT_EN
        if (gen_limit != 0 && m_gen >= int'(gen_limit)) free_ok = 0;
`endif
        if (host_req) begin
          m_mode = M_HOST;
        end else if (load_req) begin
          m_mode = M_LOAD;
          m_quad = 0;
        end else if (step || free_ok) begin
          m_mode = M_RUN;
          m_quad = 0;
        end
        if (m_mode != M_IDLE) m_wait = 0;
        else m_wait = run_en ? m_wait + 1 : 0;
      end
      M_HOST: if (!host_req) m_mode = M_IDLE;
      M_LOAD: begin
        if (mem_ack) begin
          if (m_quad == 3) begin
            m_mode = M_IDLE;
            m_quad = 0;
            m_gen  = 0;
          end else begin
            m_quad++;
          end
        end
      end
      M_RUN: begin
        if (m_quad == 3) begin
          m_mode = M_STORE;
          m_quad = 0;
        end else begin
          m_quad++;
        end
      end
      default: begin
        if (mem_ack) begin
          if (m_quad == 3) begin
            m_mode = M_IDLE;
            m_quad = 0;
            m_gen  = (m_gen + 1) % (1 << GEN_W);
          end else begin
            m_quad++;
          end
        end
      end
    endcase
  endtask

  initial begin
    int  n;
    bit  ok;
    bit  found;
    int  held[4];
    int  streak;
    int  runs;
    int  n_done;

`ifdef GEN_LIMIT_EN
    gen_limit = '0;
`endif

    // Single-step generation and dropped-step behaviour, one table row per cycle.
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_idle(0)));
    vecs.push_back(mkv(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, e_idle(0)));
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e_run(0, 0)));
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e_run(1, 0)));
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e_run(2, 0)));
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e_run(3, 0)));
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e_wm(0, 1'b0, 0)));
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e_wm(1, 1'b0, 0)));
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e_wm(2, 1'b0, 0)));
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e_wm(3, 1'b1, 0)));
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e_idle(1)));
    vecs.push_back(mkv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, e_idle(1)));
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_run(0, 1)));
    vecs.push_back(mkv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, e_run(1, 1)));
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_run(2, 1)));
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_run(3, 1)));
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_wm(0, 1'b0, 1)));
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e_wm(0, 1'b0, 1)));
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e_wm(1, 1'b0, 1)));
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e_wm(2, 1'b0, 1)));
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e_wm(3, 1'b1, 1)));
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_idle(2)));
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_idle(2)));

    // Reset then quiet: everything stays low.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      sample();
      checkOutput($sformatf("idle_quiet[%0d]", c), 32'(dut_out()), 32'(e_idle(0)));
      tick();
    end

    do_reset();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].run_en, vecs[i].step, vecs[i].load_req, vecs[i].mem_ack, vecs[i].host_req);
      sample();
      checkOutput($sformatf("vec[%0d]", i), 32'(dut_out()), 32'(vecs[i].exp_out));
      tick();
    end

    // Free-running generations with an always-ready memory.
    do_reset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int g = 0; g < 3; g++) begin
      count_idle_until_run(n, ok);
      if (!ok) checkOutput($sformatf("free_timeout%0d", g), 32'd0, 32'd1);
      checkOutput($sformatf("free_gap%0d", g), 32'(n), 32'(DELAY));
    end
    found = 0;
    for (int c = 0; c < 40; c++) begin
      sample();
      if (!busy) begin
        found = 1;
        break;
      end
      tick();
    end
    if (!found) checkOutput("free_end_timeout", 32'd0, 32'd1);
    checkOutput("free_count", 32'(gen_count), 32'd3);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Load with a memory that acknowledges on the fourth cycle of each transfer.
    held   = '{0, 0, 0, 0};
    streak = 0;
    runs   = 0;
    found  = 0;
    ok     = 0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 100; c++) begin
      sample();
      if (run) runs++;
      if (write_array) begin
        held[pos]++;
        found = 1;
        if (mem_ack) streak = 0;
        else streak++;
      end
      if (found && !busy) begin
        ok = 1;
        break;
      end
      tick();
      if (busy) load_req = 1'b0;
      mem_ack = (streak == 3);
    end
    if (!ok) checkOutput("load_timeout", 32'd0, 32'd1);
    for (int q = 0; q < 4; q++) checkOutput($sformatf("load_hold[%0d]", q), 32'(held[q]), 32'd4);
    checkOutput("load_count", 32'(gen_count), 32'd0);
    checkOutput("load_no_run", 32'(runs), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Host request raised mid-STORE is held off until IDLE.
    do_reset();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    step  = 1'b0;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      sample();
      if (write_mem) begin
        found = 1;
        break;
      end
      tick();
    end
    if (!found) checkOutput("host_store_timeout", 32'd0, 32'd1);
    tick();
    host_req = 1'b1;
    sample();
    checkOutput("host_wait0", 32'(dut_out()), 32'(e_wm(0, 1'b0, 0)));
    tick();
    sample();
    checkOutput("host_wait1", 32'(dut_out()), 32'(e_wm(0, 1'b0, 0)));
    tick();
    mem_ack = 1'b1;
    for (int q = 0; q < 4; q++) begin
      sample();
      checkOutput($sformatf("host_store_q%0d", q), 32'(host_gnt), 32'd0);
      tick();
    end
    mem_ack = 1'b0;
    sample();
    checkOutput("host_idle_cycle", 32'(dut_out()), 32'(e_idle(1)));
    tick();
    sample();
    checkOutput("host_granted", 32'(dut_out()),
                32'(pack_out(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 16'd1)));
    tick();
    host_req = 1'b0;
    sample();
    tick();
    sample();
    checkOutput("host_released", 32'(dut_out()), 32'(e_idle(1)));
    tick();

    // Reset while computing quadrant 2 aborts the generation.
    do_reset();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    step = 1'b0;
    finish_gen("rst_pre");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    step  = 1'b0;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      sample();
      if (run && pos == 2'd1) begin
        found = 1;
        break;
      end
      tick();
    end
    if (!found) checkOutput("rst_find_timeout", 32'd0, 32'd1);
    tick();
    reset = 1'b1;
    sample();
    checkOutput("rst_pos2_cycle", 32'(dut_out()), 32'(e_run(2, 1)));
    tick();
    reset = 1'b0;
    sample();
    checkOutput("rst_abort", 32'(dut_out()), 32'(e_idle(0)));
    tick();

`ifdef GEN_LIMIT_EN
    // Free-run stops at the limit while a step still advances the count.
    do_reset();
    gen_limit = 16'd2;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    n_done = 0;
    for (int c = 0; c < 120; c++) begin
      sample();
      if (gen_done) n_done++;
      tick();
    end
    checkOutput("limit_gens", 32'(n_done), 32'd2);
    checkOutput("limit_count", 32'(gen_count), 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    step = 1'b0;
    finish_gen("limit_step");
    checkOutput("limit_step_count", 32'(gen_count), 32'd3);
    gen_limit = '0;
`else
    n_done = 0;
`endif

    // Randomized traffic against the reference model.
    do_reset();
    m_mode = M_IDLE;
    m_quad = 0;
    m_gen  = 0;
    m_wait = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 29) == 0) run_en = ~run_en;
      step     = ($urandom_range(0, 9) == 0);
      load_req = ($urandom_range(0, 39) == 0);
      if (host_req) host_req = ($urandom_range(0, 3) != 0);
      else host_req = ($urandom_range(0, 29) == 0);
      mem_ack = ($urandom_range(0, 1) == 1);
      sample();
      checkOutput($sformatf("rand[%0d]", c), 32'(dut_out()), 32'(model_out()));
      model_update();
      tick();
    end
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
